// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code receiver.
//   - ps2_state_t : frame FSM state encoding (IDLE=0, DATA=1, PARITY=2, STOP=3)
//   - PS2_BREAK_CODE / PS2_EXT_CODE : prefix codes, which are passed through untouched
//   - PS2_START_LVL / PS2_STOP_LVL  : line levels of the start and stop bits
//   - ps2_parity_odd() : true when data plus parity bit carry an odd number of 1s
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  localparam logic PS2_START_LVL = 1'b0;
  localparam logic PS2_STOP_LVL  = 1'b1;

  function automatic logic ps2_parity_odd(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings the raw PS/2 pins into the clk domain.
// Both pins pass through a 2-FF synchroniser; one extra register on the
// clock path detects its falling edge. All flops reset to 1, the idle bus
// level, so leaving reset with an idle bus never produces a spurious edge.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   ps2_clk   in   raw PS/2 clock pin
//   ps2_data  in   raw PS/2 data pin
//   sync_data out  synchronised data pin
//   fall      out  one-cycle pulse on a synchronised ps2_clk falling edge
module ps2_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sync_data,
  output logic fall
);

  logic clk_meta;
  logic clk_sync;
  logic clk_prev;
  logic data_meta;
  logic data_sync;

  // Synchroniser chains plus the delayed clock copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign sync_data = data_sync;
  assign fall      = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: deserialises PS/2 keyboard frames (start, 8 data bits
// LSB first, parity, stop) into 8-bit scan codes. Prefix codes such as 0xF0
// and 0xE0 are delivered as ordinary codes for the downstream mapper.
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, odd parity is
// enforced and a parity failure drops the frame; otherwise the parity bit
// is ignored and only the stop bit gates acceptance.
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk fall mid-frame before the
//                   frame is abandoned
// Ports:
//   clk             in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   ps2_clk         in   raw PS/2 clock pin (asynchronous)
//   ps2_data        in   raw PS/2 data pin (asynchronous)
//   scan_code       out  last good scan code, held until the next good frame
//   scan_code_ready out  one-cycle strobe when scan_code updates
//   frame_err       out  one-cycle strobe when a frame is dropped
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_code_ready,
  output logic       frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  logic sync_data;
  logic fall;

  ps2_sync_edge u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .sync_data (sync_data),
    .fall      (fall)
  );

  ps2_state_t       state, state_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       code_next;
  logic             ready_next;
  logic             err_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
  logic             parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit, parity_next;
  assign parity_ok = ps2_parity_odd(shift_reg, parity_bit);
`else
  assign parity_ok = 1'b1;
`endif

  // Next-state logic. Frame bits are only acted on in cycles with a clock
  // fall; a fall also beats a simultaneous timeout.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    code_next    = scan_code;
    ready_next   = 1'b0;
    err_next     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_next  = parity_bit;
`endif

    if (state == ST_IDLE || fall) begin
      tmo_next = '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_next = tmo_cnt + 1'b1;
    end else begin
      tmo_next = tmo_cnt;
    end

    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (sync_data == PS2_START_LVL) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end
        end
        ST_DATA: begin
          shift_next   = {sync_data, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = ST_PARITY;
          end
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_next = sync_data;
`endif
          state_next = ST_STOP;
        end
        ST_STOP: begin
          if (sync_data == PS2_STOP_LVL && parity_ok) begin
            code_next  = shift_reg;
            ready_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmo_cnt >= TMO_LAST) begin
      // Keyboard stopped clocking mid-frame: abandon it.
      state_next = ST_IDLE;
      err_next   = 1'b1;
      tmo_next   = '0;
    end
  end

  // State and output registers; outputs are registered so strobes are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      scan_code       <= '0;
      scan_code_ready <= 1'b0;
      frame_err       <= 1'b0;
      tmo_cnt         <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit      <= 1'b0;
`endif
    end else begin
      state           <= state_next;
      bit_cnt         <= bit_cnt_next;
      shift_reg       <= shift_next;
      scan_code       <= code_next;
      scan_code_ready <= ready_next;
      frame_err       <= err_next;
      tmo_cnt         <= tmo_next;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit      <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: scoreboard bench for ps2_scan_receiver. The stimulus
// side bit-bangs PS/2 frames and pushes the expected event (good code or
// dropped frame, with the cycle it must appear in) onto a queue; an
// independent monitor pops and compares on every ready/error strobe.
module tb_ps2_scan_receiver;

  localparam int TMO  = 64;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_fall_cyc = 0;
  logic [7:0] model_code = 8'h00;

  ps2_scan_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .scan_code       (scan_code),
    .scan_code_ready (scan_code_ready),
    .frame_err       (frame_err)
  );

  // 100 MHz system clock and a rising-edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic oddPar(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // One PS/2 bit: data set while the clock is high, then a low half-period.
  task automatic sendBit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; the expected outcome is queued at the stop-bit fall and must
  // be visible three system clocks later.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop);
    logic good;
    exp_t e;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    sendBit(par);
    good = (stop === 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    if ($countones({data, par}) % 2 == 0) good = 1'b0;
`endif
    if (good) model_code = data;
    ps2_data = stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    e.is_err = !good;
    e.code   = model_code;
    e.cyc    = cyc + 3;
    exp_q.push_back(e);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (scan_code_ready && frame_err) begin
        checkOutput("ready_err_overlap", 32'd1, 32'd0);
      end else if (scan_code_ready || frame_err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("event_is_err", 32'(frame_err), 32'(mon_e.is_err));
          checkOutput("scan_code", 32'(scan_code), 32'(mon_e.code));
          checkOutput("event_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    exp_t       e;

    repeat (4) @(negedge clk);
    checkOutput("reset_scan_code", 32'(scan_code), 32'd0);
    checkOutput("reset_ready", 32'(scan_code_ready), 32'd0);
    checkOutput("reset_err", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Directed frames: basic code, break prefix then code back-to-back, bad stop.
    applyStimulus(8'h1C, 1'b0, 1'b1);
    repeat (3 * HALF) @(negedge clk);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    applyStimulus(8'h45, 1'b0, 1'b0);
    repeat (2 * HALF) @(negedge clk);

    // Timeout: start plus four data bits, then the clock stays high.
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'($urandom_range(0, 1)));
    e.is_err = 1'b1;
    e.code   = model_code;
    e.cyc    = last_fall_cyc + 3 + TMO;
    exp_q.push_back(e);
    repeat (TMO + 20) @(negedge clk);
    applyStimulus(8'h45, 1'b0, 1'b1);
    repeat (2 * HALF) @(negedge clk);

    // Reset mid-frame: outputs clear at once; the rest of the frame is ignored.
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(d[0] ^ d[0] ^ (8'h1C >> i) & 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_scan_code", 32'(scan_code), 32'd0);
    checkOutput("midreset_ready", 32'(scan_code_ready), 32'd0);
    checkOutput("midreset_err", 32'(frame_err), 32'd0);
    model_code = 8'h00;
    exp_q.delete();
    for (int i = 4; i < 8; i++) sendBit(1'((8'h1C >> i) & 1));
    sendBit(1'b0);
    sendBit(1'b1);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    repeat (2 * HALF) @(negedge clk);

    // Wrong parity: dropped only when parity checking is built in.
    applyStimulus(8'h1C, 1'b1, 1'b1);

    // Randomised frames with occasional bad parity, bad stop and idle gaps.
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      p = oddPar(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      applyStimulus(d, p, s);
      repeat ($urandom_range(0, 2) * HALF) @(negedge clk);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
